// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_alu_pkg
// Purpose : Shared definitions for the sequential Hack ALU / multiplier.
//           Holds the FSM state encoding and the bit positions of the six
//           Hack control bits inside the packed control vector
//           {za, na, zb, nb, f, no}.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int C_NCTRL = 6;

    // Control vector is written MSB-first in the usual Hack notation,
    // so "010011" means za=0 na=1 zb=0 nb=0 f=1 no=1.
    localparam int C_ZA = 5;
    localparam int C_NA = 4;
    localparam int C_ZB = 3;
    localparam int C_NB = 2;
    localparam int C_F  = 1;
    localparam int C_NO = 0;

endpackage
`default_nettype wire

// File: rtl/seq_alu_alu_core.sv
`default_nettype none
// ============================================================================
// Module  : alu_core
// Purpose : Purely combinational Hack ALU function.
//           x = za ? 0 : a ; x = na ? ~x : x   (same for y with zb/nb)
//           r = f ? x + y : x & y ; res = no ? ~r : r
// Ports   : a, b  - operands (WIDTH)
//           ctrl  - packed {za, na, zb, nb, f, no}
//           res   - result (WIDTH)
// Revision: 1.0 - initial release
// ============================================================================
module alu_core
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [C_NCTRL-1:0] ctrl,
    output logic [WIDTH-1:0]   res
);

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_r;

    always_comb begin
        w_x = ctrl[C_ZA] ? '0 : a;
        w_x = ctrl[C_NA] ? ~w_x : w_x;
        w_y = ctrl[C_ZB] ? '0 : b;
        w_y = ctrl[C_NB] ? ~w_y : w_y;
        // Sum wraps naturally at WIDTH bits.
        w_r = ctrl[C_F] ? (w_x + w_y) : (w_x & w_y);
        res = ctrl[C_NO] ? ~w_r : w_r;
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module  : seq_alu
// Purpose : Sequential ALU with valid/ready handshakes. ALU mode (mul=0)
//           computes the Hack function in one cycle; multiply mode (mul=1)
//           runs an unsigned shift-add multiply, one multiplier bit per
//           clock, returning the low WIDTH bits of a*b.
// Ports   : clk, reset            - clock, asynchronous active-high reset
//           in_valid / in_ready   - operation handshake
//           a, b                  - operands (WIDTH)
//           za,na,zb,nb,f,no      - Hack control bits
//           mul                   - multiply mode select
//           out, zr, ng           - registered result and flags
//           out_valid / out_ready - result handshake
//           busy                  - multiply in progress
// Revision: 1.0 - initial release
// ============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             za,
    input  logic             na,
    input  logic             zb,
    input  logic             nb,
    input  logic             f,
    input  logic             no,
    input  logic             mul,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;   // multiplicand, shifted left each step
    logic [WIDTH-1:0]   r_mplier;  // multiplier, shifted right each step
    logic [WIDTH-1:0]   r_acc;
    logic [CW-1:0]      r_cnt;

    logic [C_NCTRL-1:0] w_ctrl;
    logic [WIDTH-1:0]   w_alu_res;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_accept;

    assign w_ctrl = {za, na, zb, nb, f, no};

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a    (a),
        .b    (b),
        .ctrl (w_ctrl),
        .res  (w_alu_res)
    );

    // A result sitting in DONE may be replaced on the same edge it is
    // consumed, which is what gives back-to-back ALU ops full throughput.
    assign in_ready  = (r_state == ST_IDLE) ||
                       ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign busy      = (r_state == ST_MUL);
    assign out_valid = (r_state == ST_DONE);

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            out      <= '0;
            zr       <= 1'b1;
            ng       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        if (mul) begin
                            r_mcand  <= a;
                            r_mplier <= b;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_state  <= ST_MUL;
                        end else begin
                            out     <= w_alu_res;
                            zr      <= (w_alu_res == '0);
                            ng      <= w_alu_res[WIDTH-1];
                            r_state <= ST_DONE;
                        end
                    end else if ((r_state == ST_DONE) && out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        out     <= w_acc_next;
                        zr      <= (w_acc_next == '0);
                        ng      <= w_acc_next[WIDTH-1];
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_alu
// Purpose : Self-checking bench for seq_alu (WIDTH=16). Stimulus pushes the
//           hand-computed expected result into a queue when an op is
//           accepted; an independent monitor pops and compares each result
//           the DUT hands over.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] o;
        logic             z;
        logic             n;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             za, na, zb, nb, f, no, mul;
    logic [WIDTH-1:0] out;
    logic             zr, ng, out_valid, out_ready, busy;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .za        (za),
        .na        (na),
        .zb        (zb),
        .nb        (nb),
        .f         (f),
        .no        (no),
        .mul       (mul),
        .out       (out),
        .zr        (zr),
        .ng        (ng),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a result is consumed on the next rising edge when
    // out_valid && out_ready; sample mid-low-phase after stimulus settles.
    always @(negedge clk) begin
        #2;
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_result", 64'(out), 64'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out", 64'(out), 64'(e.o));
                check("zr",  64'(zr),  64'(e.z));
                check("ng",  64'(ng),  64'(e.n));
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic [5:0] tc, input logic tm, input logic tpush,
                        input logic [WIDTH-1:0] eo, input logic ez, input logic en);
        int n;
        a = ta;
        b = tb;
        {za, na, zb, nb, f, no} = tc;
        mul = tm;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        if (tpush) q.push_back('{eo, ez, en});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin : stim
        int n;
        logic [WIDTH-1:0] held;

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0;
        {za, na, zb, nb, f, no} = 6'b0;
        mul = 1'b0;

        @(negedge clk);
        #1;
        check("rst_out",       64'(out),       64'h0);
        check("rst_zr",        64'(zr),        64'd1);
        check("rst_ng",        64'(ng),        64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd1);

        // ALU ops back-to-back with out_ready held high.
        send(16'h5BA0, 16'h1ED2, 6'b000010, 1'b0, 1'b1, 16'h7A72, 1'b0, 1'b0);
        check("alu_valid_next", 64'(out_valid), 64'd1);
        send(16'h5BA0, 16'h1ED2, 6'b010011, 1'b0, 1'b1, 16'h3CCE, 1'b0, 1'b0);
        check("b2b_valid", 64'(out_valid), 64'd1);
        send(16'h5BA0, 16'h1ED2, 6'b101010, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        send(16'h5BA0, 16'h1ED2, 6'b000000, 1'b0, 1'b1, 16'h1A80, 1'b0, 1'b0);
        send(16'h5BA0, 16'h1ED2, 6'b111010, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
        @(negedge clk);

        // Multiply 3*5: busy for 16 cycles, then result.
        send(16'd3, 16'd5, 6'b000000, 1'b1, 1'b1, 16'h000F, 1'b0, 1'b0);
        n = 0;
        #1;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("mul_busy_cycles", 64'(n), 64'd16);
        check("mul_valid", 64'(out_valid), 64'd1);
        @(negedge clk);

        // Control bits are ignored in multiply mode.
        send(16'hFFFF, 16'hFFFF, 6'b111111, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        send(16'h1234, 16'h0010, 6'b000000, 1'b1, 1'b1, 16'h2340, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);

        // Backpressure.
        out_ready = 1'b0;
        send(16'h5BA0, 16'h1ED2, 6'b000010, 1'b0, 1'b1, 16'h7A72, 1'b0, 1'b0);
        held = out;
        a = 16'h0005; b = 16'h0003;
        {za, na, zb, nb, f, no} = 6'b010011;  // 5-3
        mul = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", 64'(in_ready),  64'd0);
            check("bp_out",      64'(out),       64'(held));
            check("bp_valid",    64'(out_valid), 64'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        q.push_back('{16'h0002, 1'b0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset in the middle of a multiply.
        send(16'd7, 16'd9, 6'b000000, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mrst_busy",  64'(busy),      64'd0);
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_out",   64'(out),       64'h0);
        check("mrst_zr",    64'(zr),        64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mrst_in_ready", 64'(in_ready),  64'd1);
        check("mrst_no_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        send(16'h5BA0, 16'h1ED2, 6'b111111, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);

        n = 0;
        while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 16, the data path width in bits (legal range 2..64).
REQ-002 The block SHALL expose port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 The block SHALL expose port reset  input  1  an asynchronous, active-high reset.
REQ-004 The block SHALL expose port in_valid  input  1  an operation is presented.
REQ-005 The block SHALL expose port in_ready  output  1  the block accepts an operation this cycle.
REQ-006 The block SHALL expose ports a, b  input  WIDTH  the operands.
REQ-007 The block SHALL expose ports za, na, zb, nb, f, no  input  1 each  Hack ALU control bits.
REQ-008 The block SHALL expose port mul  input  1  selects multiply mode; control bits are ignored when it is 1.
REQ-009 The block SHALL expose port out  output  WIDTH  the registered result.
REQ-010 The block SHALL expose ports zr, ng  output  1 each  the registered zero and negative flags of out.
REQ-011 The block SHALL expose port out_valid  output  1  out, zr and ng hold a result.
REQ-012 The block SHALL expose port out_ready  input  1  the consumer takes the result.
REQ-013 The block SHALL expose port busy  output  1  a multiply is in progress.

Function
REQ-014 An operation SHALL be accepted on a rising edge where in_valid and in_ready are both 1; a, b, the control bits and mul SHALL be captured on that edge.
REQ-015 The FSM SHALL have three states: IDLE, MUL and DONE.
REQ-016 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready).
REQ-017 ALU mode (mul=0): x = za?0:a, then x = na?~x:x; y is formed the same way from b with zb and nb; r = f?(x+y mod 2^WIDTH):(x&y); out = no?~r:r.
REQ-018 ALU mode SHALL write out on the acceptance edge, so out_valid is 1 in the next cycle (state DONE).
REQ-019 MUL mode SHALL perform an unsigned shift-add multiply, one multiplier bit per edge, and produce the low WIDTH bits of a*b.
REQ-020 MUL mode timing: acceptance edge enters state MUL with an iteration counter of 0; each MUL edge processes one bit; the WIDTH-th MUL edge writes out and enters DONE. out_valid is therefore 1 exactly WIDTH+1 cycles after acceptance.
REQ-021 busy SHALL be 1 exactly while state==MUL; in_ready SHALL be 0 while state==MUL.
REQ-022 zr SHALL be 1 if and only if out==0; ng SHALL equal out[WIDTH-1]; both SHALL be updated only on the edge that writes out.
REQ-023 In DONE with out_ready=0, out, zr, ng and out_valid SHALL hold stable.
REQ-024 In DONE with out_ready=1 and no new acceptance, the block SHALL go to IDLE and out_valid SHALL drop to 0.
REQ-025 In DONE with out_ready=1 and in_valid=1, the new operation SHALL be accepted on the same edge (back-to-back ALU ops reach one result per cycle).
REQ-026 in_valid asserted while the block is not ready SHALL have no effect, and the operation SHALL not be queued.

Reset
REQ-027 Asserting reset SHALL immediately force state=IDLE, out=0, zr=1, ng=0, out_valid=0, busy=0 and the counter and accumulator to 0.
REQ-028 Asserting reset during MUL SHALL abandon the multiply with no result produced; in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-029 Package seq_alu_pkg SHALL hold the state encoding and the control-bit index constants (ZA..NO).
REQ-030 The combinational Hack function (REQ-017) SHALL be a parametrised sub-module, alu_core, instantiated once.

Verification
REQ-031 WIDTH=16, a=0x5BA0, b=0x1ED2, ctrl 000010 (x+y) -> out=0x7A72, zr=0, ng=0, out_valid in cycle+1.
REQ-032 Same a and b, ctrl 010011 (x-y) -> out=0x3CCE; then ctrl 101010 (zero) -> out=0x0000, zr=1; issued back-to-back with out_ready=1, giving one result per cycle.
REQ-033 mul=1, a=3, b=5 -> busy high for 16 cycles, out=0x000F at cycle 17; then a=0xFFFF, b=0xFFFF -> out=0x0001, ng=0.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles after a result -> out stable, in_ready=0, the presented op is not accepted; raise out_ready -> the op is accepted on that edge.
REQ-035 Assert reset at MUL iteration 7 -> out_valid never rises for that op, out=0, zr=1, and a following op (ctrl 111111 -> out=0x0001) completes normally.
